order_tracker: RTL
==================

ORDER_TRACKER -- requirements
Module: order_tracker

Interface
REQ-001 SHALL have parameter IDX_W, default 10, meaning the order-table index width; table depth DEPTH = 2**IDX_W.
REQ-002 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-003 SHALL have port rst_n  input  1  meaning the reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  meaning a parsed book message is offered.
REQ-005 SHALL have port in_ready  output  1  meaning the block accepts in_msg this cycle.
REQ-006 SHALL have port in_msg  input  book_msg_t  meaning the message: fields mtype, side, order_id[31:0], price_tick[31:0], qty[31:0].
REQ-007 SHALL have port lvl_valid  output  1  meaning a price-level update is presented.
REQ-008 SHALL have port lvl_ready  input  1  meaning the downstream price-level book accepts the update.
REQ-009 SHALL have port lvl_side  output  side_e  meaning the side of the update.
REQ-010 SHALL have port lvl_price  output  32  meaning the price tick of the update.
REQ-011 SHALL have port lvl_inc  output  1  meaning the update direction: 1 = add lvl_qty, 0 = remove lvl_qty.
REQ-012 SHALL have port lvl_qty  output  32  meaning the unsigned magnitude of the update.
REQ-013 SHALL have port init_done  output  1  meaning the table sweep is complete.
REQ-014 SHALL have port cnt_miss  output  16  meaning a saturating count of CANCEL/EXEC messages with no matching live order.
REQ-015 SHALL have port cnt_collision  output  16  meaning a saturating count of ADD messages dropped for an occupied slot or qty 0.

Function
REQ-016 SHALL hold a DEPTH-entry table with one-cycle synchronous read; each entry holds {live, tag = order_id[31:IDX_W], side, price, qty}.
REQ-017 SHALL index the table with order_id[IDX_W-1:0].
REQ-018 SHALL use FSM states INIT, IDLE, RESOLVE and EMIT.
REQ-019 SHALL, in INIT, clear the live bit of one entry per cycle from index 0 to DEPTH-1, then go to IDLE and assert init_done.
REQ-020 SHALL assert in_ready only in IDLE.
REQ-021 SHALL, on the in_valid && in_ready edge, register in_msg, issue the table read, and go to RESOLVE.
REQ-022 SHALL define hit in RESOLVE as live && tag == registered order_id[31:IDX_W].
REQ-023 SHALL, for ADD with the slot not live and qty != 0, write {1, tag, side, price_tick, qty} and emit inc=1, qty=msg qty, at the message side/price.
REQ-024 SHALL, for ADD with the slot live (any tag) or qty == 0, leave the table unchanged, increment cnt_collision, and emit nothing.
REQ-025 SHALL, for CANCEL on a hit, clear live and emit inc=0, qty=stored qty, at the stored side/price.
REQ-026 SHALL, for EXEC on a hit, compute dq = min(msg qty, stored qty), write back stored-dq, and clear live if the result is 0.
REQ-027 SHALL, for EXEC on a hit, emit inc=0, qty=dq at the stored side/price when dq > 0, and emit nothing when dq == 0.
REQ-028 SHALL, for CANCEL or EXEC on a miss, leave the table unchanged, increment cnt_miss, and emit nothing.
REQ-029 SHALL leave RESOLVE after exactly one cycle: to EMIT with lvl_* registered when an update is produced, otherwise to IDLE.
REQ-030 SHALL, in EMIT, hold lvl_valid=1 with lvl_* stable until lvl_ready is sampled high, then go to IDLE.
REQ-031 SHALL assert lvl_valid on the second edge after acceptance, giving a maximum throughput of one message per 3 cycles.
REQ-032 SHALL saturate each counter at 16'hFFFF.
REQ-033 SHALL drop mtype values other than ADD, CANCEL and EXEC without effect.

Reset
REQ-034 SHALL, on rst_n low, asynchronously set state=INIT, the sweep index to 0, init_done=0, in_ready=0, lvl_valid=0, lvl_side=SIDE_BID, lvl_inc=0, lvl_price=0, lvl_qty=0, cnt_miss=0 and cnt_collision=0.
REQ-035 SHALL, when reset is asserted mid-operation, discard any pending message or update and rerun the full INIT sweep.

Verification
REQ-036 SHALL cover reset: after release, in_ready=0 for exactly DEPTH cycles, then init_done=1 and in_ready=1.
REQ-037 SHALL cover ADD: ADD id=5, BID, price=100, qty=50 -> lvl_valid 2 edges later with BID, 100, inc=1, qty=50; lvl_ready held low 4 cycles -> outputs stable and in_ready=0 throughout.
REQ-038 SHALL cover EXEC: after the ADD above, EXEC id=5 qty=20 -> dec 20 @100; then EXEC id=5 qty=40 -> dec 30 and the slot freed; then CANCEL id=5 -> cnt_miss=1 and no lvl_valid.
REQ-039 SHALL cover collision: ADD id=7 then ADD id=7+DEPTH -> second dropped, cnt_collision=1; CANCEL id=7+DEPTH -> miss (tag mismatch); CANCEL id=7 -> dec of the original qty.
REQ-040 SHALL cover counter saturation: 65540 misses -> cnt_miss=16'hFFFF.
REQ-041 SHALL cover reset mid-EMIT: lvl_valid drops immediately, the sweep reruns, and a CANCEL of the previously added id -> miss.

Source files
------------

// File: rtl/order_tracker.sv
// order_tracker: order-id keyed table that turns ADD / CANCEL / EXEC book
// messages into signed price-level updates for a downstream level book.
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/in_msg     message input (accepted only in IDLE)
//   lvl_valid/lvl_ready/lvl_*    price-level update output (held until taken)
//   init_done                    table live-bit sweep finished
//   cnt_miss / cnt_collision     saturating drop counters
package order_tracker_pkg;
  typedef enum logic [1:0] {MSG_ADD, MSG_CANCEL, MSG_EXEC, MSG_RSVD} mtype_e;
  typedef enum logic {SIDE_BID, SIDE_ASK} side_e;
  typedef struct packed {
    mtype_e      mtype;
    side_e       side;
    logic [31:0] order_id;
    logic [31:0] price_tick;
    logic [31:0] qty;
  } book_msg_t;
endpackage

module order_tracker
  import order_tracker_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  book_msg_t   in_msg,
  output logic        lvl_valid,
  input  logic        lvl_ready,
  output side_e       lvl_side,
  output logic [31:0] lvl_price,
  output logic        lvl_inc,
  output logic [31:0] lvl_qty,
  output logic        init_done,
  output logic [15:0] cnt_miss,
  output logic [15:0] cnt_collision
);
  localparam int DEPTH = 2**IDX_W;
  localparam int TAG_W = 32 - IDX_W;

  typedef enum logic [1:0] {INIT, IDLE, RESOLVE, EMIT} state_e;

  typedef struct packed {
    logic             live;
    logic [TAG_W-1:0] tag;
    side_e            side;
    logic [31:0]      price;
    logic [31:0]      qty;
  } entry_t;

  state_e           state, state_n;
  logic [IDX_W-1:0] sweep;
  book_msg_t        msg;
  entry_t           tbl [DEPTH];
  entry_t           rd;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  entry_t           wr_data;
  logic             emit, emit_inc;
  side_e            emit_side;
  logic [31:0]      emit_price, emit_qty;
  logic             miss_inc, col_inc;
  logic             hit, accept;
  logic [31:0]      dq, rem;

  assign in_ready  = (state == IDLE);
  assign init_done = (state != INIT);
  assign accept    = in_valid && in_ready;

  // rd holds the slot read on acceptance; hit compares the upper id bits.
  assign hit = rd.live && (rd.tag == msg.order_id[31:IDX_W]);
  assign dq  = (msg.qty < rd.qty) ? msg.qty : rd.qty;
  assign rem = rd.qty - dq;

  always_comb begin
    state_n    = state;
    wr_en      = 1'b0;
    wr_idx     = msg.order_id[IDX_W-1:0];
    wr_data    = rd;
    emit       = 1'b0;
    emit_inc   = 1'b0;
    emit_side  = rd.side;
    emit_price = rd.price;
    emit_qty   = rd.qty;
    miss_inc   = 1'b0;
    col_inc    = 1'b0;
    case (state)
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = sweep;
        wr_data = '0;
        if (&sweep) state_n = IDLE;
      end
      IDLE: if (in_valid) state_n = RESOLVE;
      RESOLVE: begin
        state_n = IDLE;
        case (msg.mtype)
          MSG_ADD: begin
            // An occupied slot is a collision regardless of tag.
            if (!rd.live && msg.qty != '0) begin
              wr_en      = 1'b1;
              wr_data    = '{live: 1'b1, tag: msg.order_id[31:IDX_W], side: msg.side,
                             price: msg.price_tick, qty: msg.qty};
              emit       = 1'b1;
              emit_inc   = 1'b1;
              emit_side  = msg.side;
              emit_price = msg.price_tick;
              emit_qty   = msg.qty;
            end else col_inc = 1'b1;
          end
          MSG_CANCEL: begin
            if (hit) begin
              wr_en        = 1'b1;
              wr_data.live = 1'b0;
              emit         = 1'b1;
            end else miss_inc = 1'b1;
          end
          MSG_EXEC: begin
            if (hit) begin
              wr_en        = 1'b1;
              wr_data.qty  = rem;
              wr_data.live = (rem != '0);
              emit         = (dq != '0);
              emit_qty     = dq;
            end else miss_inc = 1'b1;
          end
          default: ;
        endcase
        if (emit) state_n = EMIT;
      end
      EMIT: if (lvl_ready) state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  // Table storage: one read port (on acceptance) and one write port
  // (sweep or resolve), never active in the same state.
  always_ff @(posedge clk) begin
    if (accept) rd <= tbl[in_msg.order_id[IDX_W-1:0]];
    if (wr_en)  tbl[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      sweep         <= '0;
      msg           <= '0;
      lvl_valid     <= 1'b0;
      lvl_side      <= SIDE_BID;
      lvl_price     <= '0;
      lvl_inc       <= 1'b0;
      lvl_qty       <= '0;
      cnt_miss      <= '0;
      cnt_collision <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) sweep <= sweep + 1'b1;
      if (accept) msg <= in_msg;
      if (state == RESOLVE && emit) begin
        lvl_valid <= 1'b1;
        lvl_side  <= emit_side;
        lvl_price <= emit_price;
        lvl_inc   <= emit_inc;
        lvl_qty   <= emit_qty;
      end else if (state == EMIT && lvl_ready) begin
        lvl_valid <= 1'b0;
      end
      if (miss_inc && cnt_miss != 16'hFFFF) cnt_miss <= cnt_miss + 16'd1;
      if (col_inc && cnt_collision != 16'hFFFF) cnt_collision <= cnt_collision + 16'd1;
    end
  end

endmodule
